// File: rtl/layer_serializer.sv
// Parallel-to-serial stage between two fully connected layers: captures a layer's
// NN-word output vector in one cycle and replays it one word per cycle, neuron 0 first.
module layer_serializer #(
  parameter int unsigned NN        = 30,
  parameter int unsigned dataWidth = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NN-1:0]           i_valid,
  input  logic [NN*dataWidth-1:0] i_data,
  output logic                    o_valid,
  output logic [dataWidth-1:0]    o_data,
  output logic                    o_last,
  output logic                    busy,
  output logic                    overrun,
  output logic                    valid_err
);

  localparam int unsigned CW = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NN - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e                          state_q, state_d;
  logic [CW-1:0]                   count_q, count_d;
  logic [NN-1:0][dataWidth-1:0]    buffer_q, buffer_d;
  logic                            o_valid_q, o_valid_d;
  logic [dataWidth-1:0]            o_data_q, o_data_d;
  logic                            o_last_q, o_last_d;
  logic                            overrun_q, overrun_d;
  logic                            valid_err_q, valid_err_d;

  logic                            trigger_c;
  logic                            mixed_c;
  logic                            at_last_c;
  logic                            capture_c;
  logic [CW-1:0]                   count_inc_c;

  assign trigger_c   = i_valid[0];
  assign mixed_c     = (i_valid != '0) && (i_valid != '1);
  assign at_last_c   = (count_q == LAST_IDX);
  assign count_inc_c = count_q + CW'(1);

  // A capture is accepted when idle or on the edge that retires the last word.
  assign capture_c   = trigger_c && ((state_q == IDLE) || at_last_c);

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    buffer_d    = buffer_q;
    o_valid_d   = o_valid_q;
    o_data_d    = o_data_q;
    o_last_d    = o_last_q;
    overrun_d   = overrun_q;
    valid_err_d = valid_err_q | mixed_c;

    case (state_q)
      IDLE: begin
        o_valid_d = 1'b0;
        o_last_d  = 1'b0;
      end
      SEND: begin
        if (at_last_c) begin
          state_d   = IDLE;
          count_d   = '0;
          o_valid_d = 1'b0;
          o_last_d  = 1'b0;
        end else begin
          count_d  = count_inc_c;
          o_data_d = buffer_q[count_inc_c];
          o_last_d = (count_inc_c == LAST_IDX);
          if (trigger_c) begin
            overrun_d = 1'b1;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        count_d   = '0;
        o_valid_d = 1'b0;
        o_last_d  = 1'b0;
      end
    endcase

    // Word 0 goes straight to the output so the burst starts one cycle after capture.
    if (capture_c) begin
      state_d   = SEND;
      count_d   = '0;
      buffer_d  = i_data;
      o_valid_d = 1'b1;
      o_data_d  = i_data[dataWidth-1:0];
      o_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      buffer_q    <= '0;
      o_valid_q   <= 1'b0;
      o_data_q    <= '0;
      o_last_q    <= 1'b0;
      overrun_q   <= 1'b0;
      valid_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      buffer_q    <= buffer_d;
      o_valid_q   <= o_valid_d;
      o_data_q    <= o_data_d;
      o_last_q    <= o_last_d;
      overrun_q   <= overrun_d;
      valid_err_q <= valid_err_d;
    end
  end

  assign o_valid   = o_valid_q;
  assign o_data    = o_data_q;
  assign o_last    = o_last_q;
  assign busy      = o_valid_q;
  assign overrun   = overrun_q;
  assign valid_err = valid_err_q;

endmodule
